mem_bus_arbiter: RTL

//  Shares the single data port of the on-chip RAM between two bus masters:
//  M0 = CPU data port, M1 = UART boot-load / DMA engine.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_pick.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and owner IDs for the two-master RAM arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; MEM_ARB_RR_EN turns ties into round robin
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant,
  output logic owner
);

  assign grant = req0 | req1;

`ifdef MEM_ARB_RR_EN
  // on a tie the master that did not win last time takes the bus
  assign owner = (req0 & req1) ? ~last_owner : req0 ? OWN_M0 : req1 ? OWN_M1 : last_owner;
`else
  // fixed priority to M0; with no request the value is a don't-care held at last_owner
  assign owner = req0 ? OWN_M0 : req1 ? OWN_M1 : last_owner;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the RAM data port between CPU (M0) and boot/DMA (M1); optional MEM_ARB_RR_EN
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_m0_req,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W/8-1:0] i_m0_wr,
  output logic                o_m0_ack,
  input  logic                i_m1_req,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wr,
  output logic                o_m1_ack,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [ADDR_W-1:0]   o_s_addr,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wr,
  output logic                o_s_rd,
  input  logic [DATA_W-1:0]   i_s_rdata,
  output logic                o_busy
);

  localparam int BE_W = DATA_W / 8;

  state_t            state;
  logic              owner;
  logic              last_owner;
  logic              rd_op;
  logic [2:0]        cnt;
  logic              pick_grant;
  logic              pick_owner;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [BE_W-1:0]   sel_wr;

  mem_arb_pick u_pick (
    .req0       (i_m0_req),
    .req1       (i_m1_req),
    .last_owner (last_owner),
    .grant      (pick_grant),
    .owner      (pick_owner)
  );

  assign sel_addr  = pick_owner ? i_m1_addr  : i_m0_addr;
  assign sel_wdata = pick_owner ? i_m1_wdata : i_m0_wdata;
  assign sel_wr    = pick_owner ? i_m1_wr    : i_m0_wr;
  assign o_busy    = state != ST_IDLE;

  // access sequencer: grant, one strobe cycle, fixed read latency, one-cycle ack
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      owner      <= OWN_M0;
      last_owner <= OWN_M1;
      rd_op      <= 1'b0;
      cnt        <= '0;
      o_m0_ack   <= 1'b0;
      o_m1_ack   <= 1'b0;
      o_rdata    <= '0;
      o_s_addr   <= '0;
      o_s_wdata  <= '0;
      o_s_wr     <= '0;
      o_s_rd     <= 1'b0;
    end else begin
      o_m0_ack <= 1'b0;
      o_m1_ack <= 1'b0;
      unique case (state)
        ST_IDLE: if (pick_grant) begin
          owner      <= pick_owner;
          last_owner <= pick_owner;
          o_s_addr   <= sel_addr;
          o_s_wdata  <= sel_wdata;
          o_s_wr     <= sel_wr;
          o_s_rd     <= ~|sel_wr;
          rd_op      <= ~|sel_wr;
          state      <= ST_ACCESS;
        end
        ST_ACCESS: begin
          o_s_wr <= '0;
          o_s_rd <= 1'b0;
          cnt    <= 3'(RD_LAT - 1);
          state  <= ST_WAIT;
        end
        ST_WAIT: if (cnt == '0) begin
          o_rdata  <= rd_op ? i_s_rdata : o_rdata;
          o_m0_ack <= owner == OWN_M0;
          o_m1_ack <= owner == OWN_M1;
          state    <= ST_RESP;
        end else begin
          cnt <= cnt - 3'd1;
        end
        ST_RESP: state <= ST_IDLE;
      endcase
    end
  end

endmodule
